// File: rtl/nto1_rr_muxer.sv
// nto1_rr_muxer: N-to-1 multiplexer with a registered output stage and
// valid/ready handshakes on both sides. The channel moved into the output
// register is chosen either round-robin (mode=0) or by the select input b
// (mode=1). The round-robin pointer is exported on dbg_ptr for observation.
//
// Handshake rule (both sides): a word moves across an interface on a rising
// clock edge exactly when valid and ready are both 1 in the preceding cycle.
// A producer keeps valid and data stable until it sees ready; ready may be
// asserted without valid and is never allowed to depend on it combinationally
// beyond the grant decision of the channel it is offered to.
module nto1_rr_muxer #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N*W-1:0] x,
  input  logic [N-1:0]   x_valid,
  output logic [N-1:0]   x_ready,
  input  logic           mode,
  input  logic [SW-1:0]  b,
  output logic [W-1:0]   z,
  output logic           z_valid,
  input  logic           z_ready,
  output logic [SW-1:0]  z_sel,
  output logic [SW-1:0]  dbg_ptr
);

  // Round-robin pointer: channel with the highest priority next cycle.
  logic [SW-1:0] ptr;

  logic          load;
  logic          xfer;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic          fx_found;
  logic [SW-1:0] fx_idx;
  logic          grant_exists;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_word;

  // (base + off) mod N for off in 0..N; keeps indices inside 0..N-1 even
  // when N is not a power of two.
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return SW'(s);
  endfunction

  // Output register can accept a new word when empty or draining this cycle.
  assign load = ~z_valid | z_ready;

  // Round-robin scan: offsets visited from far to near so the nearest valid
  // channel to ptr (offset 0 first) is the one left in rr_idx.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (x_valid[wrap_add(ptr, k)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_add(ptr, k);
      end
    end
  end

  // Fixed select: only an in-range b with a valid word yields a grant.
  always_comb begin
    fx_found = 1'b0;
    fx_idx   = b;
    for (int i = 0; i < N; i++) begin
      if ((b == SW'(i)) && x_valid[i]) fx_found = 1'b1;
    end
  end

  assign grant_exists = mode ? fx_found : rr_found;
  assign grant_idx    = mode ? fx_idx   : rr_idx;

  // A word is taken only when not in reset; reset discards everything.
  assign xfer = load & grant_exists & ~reset;

  // One-hot ready for the granted channel and its data word.
  always_comb begin
    x_ready    = '0;
    grant_word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        x_ready[i] = xfer;
        grant_word = x[i*W +: W];
      end
    end
  end

  // Output register and round-robin pointer update.
  always_ff @(posedge clock) begin
    if (reset) begin
      z       <= '0;
      z_valid <= 1'b0;
      z_sel   <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (xfer) begin
        z       <= grant_word;
        z_sel   <= grant_idx;
        z_valid <= 1'b1;
        if (!mode) ptr <= wrap_add(grant_idx, 1);
      end else begin
        // Nothing to load: mark empty, keep stale data and source index.
        z_valid <= 1'b0;
      end
    end
  end

  assign dbg_ptr = ptr;

endmodule
